// File: rtl/dmem_resp_if.sv
// Load/store request and response bundle between the memory stage and dmem_resp.
interface dmem_resp_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_size;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_resp.sv
// Data-memory responder: one load/store at a time from a word-organised RAM,
// answered after WAIT_CYC wait states with a single-cycle response pulse.
module dmem_resp #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned WAIT_CYC = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  dmem_resp_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam int unsigned LP_DEPTH    = 1 << ADDR_W;
  localparam logic [3:0]  LP_CNT_INIT = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_size;
  logic        r_ready;
  logic        r_rsp_valid;
  logic [31:0] r_rdata;
  logic        r_err;

  logic [31:0] r_mem [LP_DEPTH];

  logic              w_accept;
  logic              w_live;
  logic              w_commit;
  logic              w_we;
  logic [31:0]       w_addr;
  logic [31:0]       w_wdata;
  logic [2:0]        w_size;
  logic              w_illegal;
  logic              w_misal;
  logic              w_oor;
  logic              w_err;
  logic [ADDR_W-1:0] w_idx;
  logic [31:0]       w_word;
  logic [31:0]       w_shift;
  logic [31:0]       w_ext;
  logic [31:0]       w_load;
  logic [3:0]        w_be;
  logic [31:0]       w_wlane;
  logic              w_mem_we;

  assign w_accept = bus.req_valid && r_ready;

  // With WAIT_CYC=0 the accept edge is also the commit edge, so decode must
  // see the live bus request in IDLE and the latched copy afterwards.
  assign w_live  = (r_state == IDLE);
  assign w_we    = w_live ? bus.req_we    : r_we;
  assign w_addr  = w_live ? bus.req_addr  : r_addr;
  assign w_wdata = w_live ? bus.req_wdata : r_wdata;
  assign w_size  = w_live ? bus.req_size  : r_size;

  assign w_commit = ((r_state == IDLE) && w_accept && (WAIT_CYC == 0)) ||
                    ((r_state == WAIT) && (r_cnt == 4'd0));

  always_comb begin
    w_illegal = (w_size == 3'b011) || (w_size == 3'b110) || (w_size == 3'b111);
    w_misal   = ((w_size[1:0] == 2'b01) && w_addr[0]) ||
                ((w_size[1:0] == 2'b10) && (w_addr[1:0] != 2'b00));
    w_oor     = |(w_addr >> (ADDR_W + 2));
    w_err     = w_illegal || w_misal || w_oor;
  end

  assign w_idx   = w_addr[ADDR_W+1:2];
  assign w_word  = r_mem[w_idx];
  assign w_shift = w_word >> {w_addr[1:0], 3'b000};

  always_comb begin
    w_ext = w_word;
    case (w_size)
      3'b000:  w_ext = {{24{w_shift[7]}}, w_shift[7:0]};
      3'b001:  w_ext = {{16{w_shift[15]}}, w_shift[15:0]};
      3'b100:  w_ext = {24'd0, w_shift[7:0]};
      3'b101:  w_ext = {16'd0, w_shift[15:0]};
      default: w_ext = w_word;
    endcase
    w_load = (w_err || w_we) ? '0 : w_ext;
  end

  always_comb begin
    w_be    = 4'b1111;
    w_wlane = w_wdata;
    case (w_size[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_addr[1:0];
        w_wlane = {4{w_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = w_addr[1] ? 4'b1100 : 4'b0011;
        w_wlane = {2{w_wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wlane = w_wdata;
      end
    endcase
  end

  // Gating with rst_n keeps a store from landing while reset is held.
  assign w_mem_we = w_commit && w_we && !w_err && rst_n;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wlane[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_size      <= '0;
      r_ready     <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we    <= bus.req_we;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            r_size  <= bus.req_size;
            r_ready <= 1'b0;
            if (WAIT_CYC == 0) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rdata     <= w_load;
              r_err       <= w_err;
            end else begin
              r_state <= WAIT;
              r_cnt   <= LP_CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rdata     <= w_load;
            r_err       <= w_err;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready = r_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: vector table through a scoreboard on a WAIT_CYC=1
// instance, plus throughput and mid-transaction reset sequences.
module tb_dmem_resp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_resp_if bus1();
  dmem_resp_if bus3();

  dmem_resp #(.ADDR_W(10), .WAIT_CYC(1)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  dmem_resp #(.ADDR_W(10), .WAIT_CYC(3)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus3)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic add(input string nm, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [2:0] size,
                     input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.name = nm; v.we = we; v.addr = addr; v.wdata = wdata; v.size = size;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vt.push_back(v);
  endtask

  task automatic do_req(input vec_t v, input bit expect_rsp);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    bus1.req_valid = 1'b1;
    bus1.req_we    = v.we;
    bus1.req_addr  = v.addr;
    bus1.req_wdata = v.wdata;
    bus1.req_size  = v.size;
    while (!bus1.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus1.req_ready) begin
      total++; bad++;
      $display("FAIL %s_accept: req_ready never rose within 50 cycles", v.name);
      bus1.req_valid = 1'b0;
    end else begin
      if (expect_rsp) begin
        e.name = v.name; e.rdata = v.exp_rdata; e.err = v.exp_err; e.acc = cyc + 1;
        sb.push_back(e);
      end
      @(posedge clk);
      #1 bus1.req_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL rsp_timeout: %0d responses outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    vec_t v;
    bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = '0;
    bus1.req_wdata = '0;   bus1.req_size = 3'b010;
    bus3.req_valid = 1'b0; bus3.req_we = 1'b0; bus3.req_addr = '0;
    bus3.req_wdata = '0;   bus3.req_size = 3'b010;

    add("st_w_10",  1'b1, 32'h10,       32'hDEADBEEF, 3'b010, 32'h00000000, 1'b0);
    add("ld_w_10",  1'b0, 32'h10,       32'h0,        3'b010, 32'hDEADBEEF, 1'b0);
    add("st_w_10z", 1'b1, 32'h10,       32'h0,        3'b010, 32'h00000000, 1'b0);
    add("st_b_13",  1'b1, 32'h13,       32'hABCDEF80, 3'b000, 32'h00000000, 1'b0);
    add("ld_b_13",  1'b0, 32'h13,       32'h0,        3'b000, 32'hFFFFFF80, 1'b0);
    add("ld_bu_13", 1'b0, 32'h13,       32'h0,        3'b100, 32'h00000080, 1'b0);
    add("ld_w_10b", 1'b0, 32'h10,       32'h0,        3'b010, 32'h80000000, 1'b0);
    add("st_w_20",  1'b1, 32'h20,       32'hAAAAAAAA, 3'b010, 32'h00000000, 1'b0);
    add("st_h_22",  1'b1, 32'h22,       32'h56781234, 3'b001, 32'h00000000, 1'b0);
    add("ld_w_20",  1'b0, 32'h20,       32'h0,        3'b010, 32'h1234AAAA, 1'b0);
    add("ld_h_22",  1'b0, 32'h22,       32'h0,        3'b001, 32'h00001234, 1'b0);
    add("ld_h_20",  1'b0, 32'h20,       32'h0,        3'b001, 32'hFFFFAAAA, 1'b0);
    add("ld_hu_20", 1'b0, 32'h20,       32'h0,        3'b101, 32'h0000AAAA, 1'b0);
    add("ld_w_11",  1'b0, 32'h11,       32'h0,        3'b010, 32'h00000000, 1'b1);
    add("st_h_21",  1'b1, 32'h21,       32'h0000FFFF, 3'b001, 32'h00000000, 1'b1);
    add("ld_w_20b", 1'b0, 32'h20,       32'h0,        3'b010, 32'h1234AAAA, 1'b0);
    add("ld_sz3",   1'b0, 32'h20,       32'h0,        3'b011, 32'h00000000, 1'b1);
    add("ld_w_20c", 1'b0, 32'h20,       32'h0,        3'b010, 32'h1234AAAA, 1'b0);
    add("ld_sz6",   1'b0, 32'h20,       32'h0,        3'b110, 32'h00000000, 1'b1);
    add("ld_sz7",   1'b0, 32'h20,       32'h0,        3'b111, 32'h00000000, 1'b1);
    add("st_w_00",  1'b1, 32'h0,        32'h01020304, 3'b010, 32'h00000000, 1'b0);
    add("st_w_oor", 1'b1, 32'h1000,     32'h55555555, 3'b010, 32'h00000000, 1'b1);
    add("ld_w_00",  1'b0, 32'h0,        32'h0,        3'b010, 32'h01020304, 1'b0);
    add("ld_w_oor", 1'b0, 32'hFFFFFFFC, 32'h0,        3'b010, 32'h00000000, 1'b1);
    add("st_b_11",  1'b1, 32'h11,       32'h1234567F, 3'b000, 32'h00000000, 1'b0);
    add("ld_b_11",  1'b0, 32'h11,       32'h0,        3'b000, 32'h0000007F, 1'b0);
    add("ld_hu_12", 1'b0, 32'h12,       32'h0,        3'b101, 32'h00008000, 1'b0);
    add("ld_h_12",  1'b0, 32'h12,       32'h0,        3'b001, 32'hFFFF8000, 1'b0);
    add("ld_w_10c", 1'b0, 32'h10,       32'h0,        3'b010, 32'h80007F00, 1'b0);

    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n && bus1.rsp_valid) begin
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_rsp: rsp_valid=1 expected 0 (cycle %0d)", cyc);
          end else begin
            e = sb.pop_front();
            chk({e.name, "_rdata"}, bus1.rsp_rdata, e.rdata);
            chk({e.name, "_err"}, {31'd0, bus1.rsp_err}, {31'd0, e.err});
            chk({e.name, "_latency"}, 32'(cyc - e.acc), 32'd1);
            chk({e.name, "_ready_in_resp"}, {31'd0, bus1.req_ready}, 32'd0);
          end
        end
      end
      begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready",     {31'd0, bus1.req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, bus1.rsp_valid}, 32'd0);
    chk("rst_rdata",     bus1.rsp_rdata,          32'd0);
    chk("rst_err",       {31'd0, bus1.rsp_err},   32'd0);
    chk("rst3_ready",    {31'd0, bus3.req_ready}, 32'd1);

    for (int i = 0; i < vt.size(); i++) begin
      do_req(vt[i], 1'b1);
      wait_done();
    end

    // Reset while a store sits in WAIT: no response, store is discarded.
    v.name = "st_rst"; v.we = 1'b1; v.addr = 32'h10; v.wdata = 32'hCAFEF00D;
    v.size = 3'b010; v.exp_rdata = '0; v.exp_err = 1'b0;
    do_req(v, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready",     {31'd0, bus1.req_ready}, 32'd1);
    chk("midrst_rsp_valid", {31'd0, bus1.rsp_valid}, 32'd0);
    chk("midrst_rdata",     bus1.rsp_rdata,          32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("postrst_no_rsp", {31'd0, bus1.rsp_valid}, 32'd0);
    end
    v.name = "ld_after_rst"; v.we = 1'b0; v.addr = 32'h10; v.wdata = '0;
    v.size = 3'b010; v.exp_rdata = 32'h80007F00; v.exp_err = 1'b0;
    do_req(v, 1'b1);
    wait_done();

    // Continuous req_valid on the WAIT_CYC=3 instance: accept every 5 cycles.
    @(negedge clk);
    bus3.req_valid = 1'b1;
    bus3.req_we    = 1'b1;
    bus3.req_addr  = 32'h4;
    bus3.req_wdata = 32'h0BADF00D;
    bus3.req_size  = 3'b010;
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("thr_ready_%0d", i), {31'd0, bus3.req_ready}, {31'd0, (i % 5) == 0});
      chk($sformatf("thr_rsp_%0d", i),   {31'd0, bus3.rsp_valid}, {31'd0, (i % 5) == 4});
      if ((i % 5) == 4) begin
        chk($sformatf("thr_err_%0d", i), {31'd0, bus3.rsp_err}, 32'd0);
      end
      @(negedge clk);
    end
    bus3.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("thr_idle_ready", {31'd0, bus3.req_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
